// File: rtl/jt12_bm_pkg.sv
// Shared definitions for jt12_bus_master: FSM encoding, command word layout and fixed timing.
package jt12_bm_pkg;

  localparam int unsigned CMD_W      = 17;
  localparam int unsigned SETTLE_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_GAP    = 3'd2,
    S_DATA   = 3'd3,
    S_SETTLE = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  // Command word {part, reg, val}
  typedef struct packed {
    logic       part;
    logic [7:0] rg;
    logic [7:0] val;
  } cmd_t;

  function automatic logic [1:0] mk_addr(input logic part, input logic is_data);
    return {part, is_data};
  endfunction

endpackage

// File: rtl/jt12_bm_fifo.sv
// Synchronous first-word-fall-through command FIFO with registered full/empty and flush.
module jt12_bm_fifo
  import jt12_bm_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [CMD_W-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [CMD_W-1:0] o_dout
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nx;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  // Flush wins over both push and pop in the same cycle
  assign w_do_push  = i_push && !r_full && !i_flush;
  assign w_do_pop   = i_pop && !r_empty && !i_flush;
  assign w_count_nx = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nx;
      r_full  <= (w_count_nx == (AW+1)'(DEPTH));
      r_empty <= (w_count_nx == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/jt12_bus_master.sv
// Host-side initiator for the JT12 CPU write port: queues commands and serialises address/data writes.
// Optional JT12_ADDR_CACHE_EN skips the address write when {part,reg} matches the last one written.
module jt12_bus_master
  import jt12_bm_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned GAP_CYC = 1,
  parameter int unsigned BUSY_TO = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_part,
  input  logic [7:0] i_cmd_reg,
  input  logic [7:0] i_cmd_val,
  input  logic       i_flush,
  output logic [1:0] o_bus_addr,
  output logic [7:0] o_bus_dout,
  output logic       o_bus_write,
  input  logic       i_bus_busy,
  output logic       o_idle,
  output logic       o_to_err
);

  localparam int unsigned CNT_W = $clog2(BUSY_TO + 16);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CMD_W-1:0] w_fifo_dout;
  cmd_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_hit;
  logic             w_timeout;
  logic             w_push_acc;
  logic             r_part;
  logic [7:0]       r_val;
  logic             r_write;
  logic             w_write_nx;
  logic [1:0]       r_addr;
  logic [1:0]       w_addr_nx;
  logic [7:0]       r_dout;
  logic [7:0]       w_dout_nx;
  logic             r_idle;
  logic             r_to_err;

  jt12_bm_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .i_din   ({i_cmd_part, i_cmd_reg, i_cmd_val}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_fifo_dout)
  );

  assign w_head     = w_fifo_dout;
  assign w_push_acc = i_cmd_valid && !w_full && !i_flush;

`ifdef JT12_ADDR_CACHE_EN
  logic       r_cache_vld;
  logic [8:0] r_cache_tag;

  assign w_hit = r_cache_vld && (r_cache_tag == {w_head.part, w_head.rg});

  // Tag is captured whenever an address write is started
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush || w_timeout) begin
      r_cache_vld <= 1'b0;
    end else if (w_pop && !w_hit) begin
      r_cache_vld <= 1'b1;
      r_cache_tag <= {w_head.part, w_head.rg};
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next state plus next values of the registered bus pins
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_write_nx = 1'b0;
    w_addr_nx  = r_addr;
    w_dout_nx  = r_dout;
    w_pop      = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !i_flush) begin
          w_pop      = 1'b1;
          w_write_nx = 1'b1;
          if (w_hit) begin
            w_state_nx = S_DATA;
            w_addr_nx  = mk_addr(w_head.part, 1'b1);
            w_dout_nx  = w_head.val;
          end else begin
            w_state_nx = S_ADDR;
            w_addr_nx  = mk_addr(w_head.part, 1'b0);
            w_dout_nx  = w_head.rg;
          end
        end
      end
      S_ADDR: begin
        w_state_nx = S_GAP;
        w_cnt_nx   = '0;
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          w_state_nx = S_DATA;
          w_write_nx = 1'b1;
          w_addr_nx  = mk_addr(r_part, 1'b1);
          w_dout_nx  = r_val;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        w_state_nx = S_SETTLE;
        w_cnt_nx   = '0;
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!i_bus_busy) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == CNT_W'(BUSY_TO - 1)) begin
          w_timeout  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_part   <= 1'b0;
      r_val    <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_idle   <= 1'b1;
      r_to_err <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_write <= w_write_nx;
      r_addr  <= w_addr_nx;
      r_dout  <= w_dout_nx;
      if (w_pop) begin
        r_part <= w_head.part;
        r_val  <= w_head.val;
      end
      if (w_timeout) r_to_err <= 1'b1;
      r_idle <= (w_state_nx == S_IDLE) && (w_empty || i_flush) && !w_push_acc;
    end
  end

  assign o_cmd_ready = ~w_full;
  assign o_bus_write = r_write;
  assign o_bus_addr  = r_addr;
  assign o_bus_dout  = r_dout;
  assign o_idle      = r_idle;
  assign o_to_err    = r_to_err;

endmodule

// File: tb/tb_jt12_bus_master.sv
// Randomised bench for jt12_bus_master: scoreboard of expected bus strobes plus a simple chip busy model.
module tb_jt12_bus_master;

  localparam int unsigned GAP = 1;
  localparam int unsigned BTO = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_part = 1'b0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_val = '0;
  logic       flush = 1'b0;
  logic       i_bus_busy = 1'b0;
  logic       o_cmd_ready;
  logic [1:0] o_bus_addr;
  logic [7:0] o_bus_dout;
  logic       o_bus_write;
  logic       o_idle;
  logic       o_to_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Scoreboard: each entry is {addr[1:0], dout[7:0]} of one expected write strobe
  logic [9:0] exp_q [$];
  logic [9:0] exp_e;
  bit         m_cv = 1'b0;
  logic [8:0] m_tag = '0;
  int         m_added = 0;
  int         n_strobe = 0;
  int         last_addr_cyc = 0;
  int         last_data_cyc = 0;
  bit         last_was_addr = 1'b0;
  bit         prev_write = 1'b0;

  bit         force_busy = 1'b0;
  int         busy_max = 4;
  int         busy_cnt = 0;

  jt12_bus_master #(
    .FIFO_AW (4),
    .GAP_CYC (GAP),
    .BUSY_TO (BTO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_part  (cmd_part),
    .i_cmd_reg   (cmd_reg),
    .i_cmd_val   (cmd_val),
    .i_flush     (flush),
    .o_bus_addr  (o_bus_addr),
    .o_bus_dout  (o_bus_dout),
    .o_bus_write (o_bus_write),
    .i_bus_busy  (i_bus_busy),
    .o_idle      (o_idle),
    .o_to_err    (o_to_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected strobes for one accepted command, in push order
  function automatic void model_push(input logic p, input logic [7:0] r, input logic [7:0] v);
`ifdef JT12_ADDR_CACHE_EN
    if (!(m_cv && m_tag == {p, r})) begin
      exp_q.push_back({p, 1'b0, r});
      m_added++;
    end
    m_cv  = 1'b1;
    m_tag = {p, r};
`else
    exp_q.push_back({p, 1'b0, r});
    m_added++;
`endif
    exp_q.push_back({p, 1'b1, v});
    m_added++;
  endfunction

  // Strobe monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (o_bus_write) begin
        chk("no_back_to_back_write", 32'(prev_write), 0);
        chk("strobe_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          chk("strobe_addr_dout", {22'd0, o_bus_addr, o_bus_dout}, {22'd0, exp_e});
        end
        if (o_bus_addr[0]) begin
          if (last_was_addr) chk("addr_to_data_spacing", 32'(cyc - last_addr_cyc), GAP + 1);
          last_data_cyc = cyc;
          last_was_addr = 1'b0;
        end else begin
          last_addr_cyc = cyc;
          last_was_addr = 1'b1;
        end
        n_strobe++;
      end
      prev_write = o_bus_write;
    end
  end

  // Chip model: busy rises after each data write and stays up for a random time
  always @(negedge clk) begin
    if (o_bus_write && o_bus_addr[0]) busy_cnt = int'($urandom_range(busy_max, 1));
    else if (busy_cnt > 0)            busy_cnt = busy_cnt - 1;
    i_bus_busy = force_busy || (busy_cnt > 0);
  end

  task automatic push_cmd(input logic p, input logic [7:0] r, input logic [7:0] v);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_part  = p;
    cmd_reg   = r;
    cmd_val   = v;
    for (int k = 0; k < 3000 && !ok; k++) begin
      if (o_cmd_ready && !flush) begin
        ok = 1'b1;
        model_push(p, r, v);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("push_accepted", 32'(ok), 1);
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (!o_idle && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(o_idle), 1);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n0;
    int k;
    int cyc_err;
    int tail;
    logic [7:0] regs [5];
    regs[0] = 8'h28; regs[1] = 8'h2A; regs[2] = 8'hB4; regs[3] = 8'h30; regs[4] = 8'hA0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_write", 32'(o_bus_write), 0);
    chk("rst_addr", 32'(o_bus_addr), 0);
    chk("rst_dout", 32'(o_bus_dout), 0);
    chk("rst_to_err", 32'(o_to_err), 0);
    chk("rst_idle", 32'(o_idle), 1);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 1);

    // Part 0 and part 1 single commands
    push_cmd(1'b0, 8'h28, 8'hF0);
    wait_idle(200);
    push_cmd(1'b1, 8'hB4, 8'hC0);
    wait_idle(200);

    // Two writes to the same register
    n0 = n_strobe;
    push_cmd(1'b0, 8'h2A, 8'h80);
    push_cmd(1'b0, 8'h2A, 8'h81);
    wait_idle(300);
`ifdef JT12_ADDR_CACHE_EN
    chk("same_reg_strobe_count", 32'(n_strobe - n0), 3);
`else
    chk("same_reg_strobe_count", 32'(n_strobe - n0), 4);
`endif

    // Fill the FIFO while the chip stays busy
    force_busy = 1'b1;
    busy_max = 8;
    for (int i = 0; i < 17; i++)
      push_cmd(1'($urandom_range(1, 0)), regs[$urandom_range(4, 0)], 8'($urandom));
    chk("full_after_17", 32'(o_cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_reg   = 8'h99;
    repeat (4) @(negedge clk);
    chk("full_holds", 32'(o_cmd_ready), 0);
    cmd_valid = 1'b0;
    force_busy = 1'b0;
    wait_idle(3000);

    // Random traffic with random busy time and push spacing
    busy_max = 40;
    for (int i = 0; i < 60; i++) begin
      push_cmd(1'($urandom_range(1, 0)), regs[$urandom_range(4, 0)], 8'($urandom));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_idle(6000);

    // Busy stuck high: timeout, sticky error, next command still issues
    busy_max = 3;
    force_busy = 1'b1;
    push_cmd(1'b0, 8'h40, 8'h11);
    push_cmd(1'b1, 8'h41, 8'h22);
    k = 0;
    while (!o_to_err && k < 1300) begin
      @(negedge clk);
      k++;
    end
    cyc_err = cyc;
    chk("timeout_raised", 32'(o_to_err), 1);
    // DATA, two SETTLE cycles, BUSY_TO cycles of WAIT, then the registered flag
    chk("timeout_latency", 32'(cyc_err - last_data_cyc), 1 + 2 + BTO);
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_after_timeout_issued", 32'(exp_q.size()), 0);
    chk("to_err_sticky", 32'(o_to_err), 1);
    force_busy = 1'b0;
    wait_idle(1300);
    chk("to_err_sticky_idle", 32'(o_to_err), 1);
    m_cv = 1'b0;

    // Flush with five queued: only the in-flight command completes
    force_busy = 1'b1;
    n0 = n_strobe;
    push_cmd(1'b0, 8'h50, 8'h01);
    tail = m_added;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 8'h51 + 8'(i), 8'h10 + 8'(i));
    tail = m_added - tail;
    for (int i = 0; i < tail; i++) void'(exp_q.pop_back());
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_reg   = 8'h77;
    @(negedge clk);
    flush     = 1'b0;
    cmd_valid = 1'b0;
    m_cv = 1'b0;
    force_busy = 1'b0;
    wait_idle(300);
    chk("flush_strobe_count", 32'(n_strobe - n0), 2);
    chk("flush_ready", 32'(o_cmd_ready), 1);

    // Reset while the data strobe is on the bus
    k = 0;
    cmd_valid = 1'b0;
    push_cmd(1'b1, 8'h55, 8'h66);
    while (!(o_bus_write && o_bus_addr[0]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("data_strobe_seen", 32'(o_bus_write && o_bus_addr[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_data_write", 32'(o_bus_write), 0);
    chk("rst_data_addr", 32'(o_bus_addr), 0);
    chk("rst_data_dout", 32'(o_bus_dout), 0);
    chk("rst_data_to_err", 32'(o_to_err), 0);
    chk("rst_data_idle", 32'(o_idle), 1);
    chk("rst_data_ready", 32'(o_cmd_ready), 1);
    rst = 1'b0;
    exp_q.delete();
    m_cv = 1'b0;
    busy_cnt = 0;
    @(negedge clk);
    push_cmd(1'b0, 8'h22, 8'h08);
    wait_idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
